ex_stall_ctrl: RTL
==================

# ex_stall_ctrl

Pipeline hazard and execute-stage sequencing controller for the five-stage core. It sits beside the EX stage and decides each cycle whether PC, IF/ID and ID/EX advance, stall, take a bubble or flush. Covered cases:
- load-use hazards;
- taken-branch flushes resolved in EX/MEM;
- multi-cycle multiply operations that hold the EX stage for `MUL_LATENCY` cycles.

## Interface
Parameters:
- `MUL_LATENCY`, default 4: number of cycles a multiply occupies EX. Legal range is 1..16.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `memRead_IDEX`  in  1  the instruction in ID/EX is a load.
- `mulStart_IDEX`  in  1  the instruction in ID/EX is a multi-cycle multiply.
- `rt_IDEX`  in  5  destination of the load in ID/EX.
- `rs_IFID`, `rt_IFID`  in  5 each  source registers of the instruction in IF/ID.
- `branchTaken_EXMEM`  in  1  the branch in EX/MEM is resolved as taken.
- `pcWrite`  out  1  PC update enable.
- `ifidWrite`  out  1  IF/ID register enable.
- `idexWrite`  out  1  ID/EX register enable.
- `bubble_IDEX`  out  1  load zeroed control signals into ID/EX.
- `bubble_EXMEM`  out  1  load zeroed control signals into EX/MEM.
- `flush_IFID`, `flush_IDEX`  out  1 each  squash the stage contents.
- `exBusy`  out  1  a multiply is in progress and not completing this cycle.
- `exDone`  out  1  a multiply completes this cycle.
- `stallCount`  out  32  count of stall cycles (see Configuration).

## Operation
- There are two states, `RUN` and `MULWAIT`, plus a 4-bit down-counter `cnt`.
- All outputs are combinational from the state, `cnt` and the inputs. Defaults: write enables 1, every other output 0.
- Evaluation in `RUN` is by priority: the first matching row applies.
  1. `branchTaken_EXMEM`:
     - outputs: `flush_IFID`=1, `flush_IDEX`=1;
     - `mulStart_IDEX` and the load-use check are ignored;
     - the state stays `RUN`.
  2. `mulStart_IDEX` with `MUL_LATENCY`>1:
     - outputs: `pcWrite`=`ifidWrite`=`idexWrite`=0, `bubble_EXMEM`=1, `exBusy`=1;
     - next state is `MULWAIT`, with `cnt`<=`MUL_LATENCY`-2.
  3. `mulStart_IDEX` with `MUL_LATENCY`=1:
     - output: `exDone`=1;
     - the state stays `RUN`.
  4. Load-use, defined as `memRead_IDEX` && `rt_IDEX`!=0 && (`rt_IDEX`==`rs_IFID` || `rt_IDEX`==`rt_IFID`):
     - outputs: `pcWrite`=0, `ifidWrite`=0, `bubble_IDEX`=1;
     - this is a single cycle, since the bubble clears the condition.
- `MULWAIT`, while `cnt`!=0:
  - same stall outputs as `RUN` row 2;
  - `cnt` decrements each cycle.
- `MULWAIT`, when `cnt`==0:
  - outputs: `exDone`=1, `exBusy`=0, all write enables 1;
  - next state is `RUN`.
- `branchTaken_EXMEM` and `memRead_IDEX` are ignored in `MULWAIT`. EX/MEM only holds bubbles there, and ID/EX is frozen.
- If `mulStart_IDEX` and `memRead_IDEX` are both 1, the encoding is illegal. The multiply path wins.

## Timing
- A multiply accepted in cycle T0 holds EX over cycles T0..T0+`MUL_LATENCY`-1:
  - stall outputs are asserted for `MUL_LATENCY`-1 cycles;
  - `exDone` is asserted in cycle T0+`MUL_LATENCY`-1;
  - the pipeline advances on the clock edge ending that cycle.
- A load-use stall lasts exactly 1 cycle. A branch flush lasts exactly 1 cycle.
- Back-to-back multiplies:
  - the cycle after `exDone`, the state is `RUN`, and a new `mulStart_IDEX` is accepted immediately;
  - there is no dead cycle between them.
- Reset has priority over everything. In the cycle `reset`=1:
  - outputs are forced to their defaults: enables 1, everything else 0, `exBusy`=0, `exDone`=0;
  - on the following edge: the state becomes `RUN`, `cnt` 0, `stallCount` 0.
- Reset in the middle of `MULWAIT` abandons the multiply and does not assert `exDone`.

## Configuration
- Macro: `EX_STALL_STATS_EN`.
- When defined:
  - `stallCount` increments on every clock edge where `reset`=0 and `pcWrite`=0;
  - it saturates at 32'hFFFFFFFF;
  - it clears to 0 on reset.
- When undefined:
  - `stallCount` is tied to 32'h0;
  - no counter flops are built.
- The port exists in both cases.

## Structure
- Package `exec_ctrl_pkg` holds:
  - the state enum (`RUN`, `MULWAIT`);
  - `CNT_W`=4;
  - `MUL_LATENCY_MAX`=16.
- Sub-module `ex_cycle_counter`:
  - a loadable, 4-bit down-counter;
  - inputs: `load`, `loadValue`, `dec`;
  - output: `zero` flag.
- The FSM, priority logic and stats counter stay in `ex_stall_ctrl`.

## Test plan
- Load-use:
  - stimulus: `memRead_IDEX`=1, `rt_IDEX`=5, `rs_IFID`=5 for one cycle;
  - response: `pcWrite`=0, `ifidWrite`=0, `bubble_IDEX`=1 in that cycle only;
  - repeat with `rt_IDEX`=0: no stall.
- Multiply with `MUL_LATENCY`=4:
  - stimulus: `mulStart_IDEX` held at T0;
  - response: stall plus `bubble_EXMEM` in T0..T2, `exDone`=1 at T3, enables 1 at T3;
  - a second `mulStart_IDEX` at T4 repeats the pattern.
- Branch priority:
  - stimulus: `branchTaken_EXMEM`=1 together with `mulStart_IDEX`=1 and a load-use match;
  - response: only `flush_IFID`/`flush_IDEX`=1, state remains `RUN`, no stall.
- Reset mid-multiply:
  - stimulus: `reset` asserted at T1 of a 4-cycle multiply;
  - response: defaults in the reset cycle, `RUN` afterwards, `exDone` never asserted.
- `MUL_LATENCY`=1:
  - stimulus: `mulStart_IDEX`=1;
  - response: `exDone`=1 in the same cycle, no stall.
- With `EX_STALL_STATS_EN` defined:
  - stimulus: one load-use stall plus one 4-cycle multiply;
  - response: `stallCount`=4, cleared to 0 by reset;
  - without the macro, `stallCount` stays 0.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the execute-stage sequencing controller.
//   - exState_t       : controller state (RUN / MULWAIT)
//   - CNT_W           : width of the multiply cycle counter
//   - MUL_LATENCY_MAX : largest supported multiply latency
//   - isLoadUse()     : load-use hazard detect between ID/EX and IF/ID
package exec_ctrl_pkg;

    localparam int CNT_W           = 4;
    localparam int MUL_LATENCY_MAX = 16;

    typedef enum logic {
        RUN     = 1'b0,
        MULWAIT = 1'b1
    } exState_t;

    // A load into r0 never creates a dependency, since r0 is hardwired.
    function automatic logic isLoadUse(
        input logic       memRead,
        input logic [4:0] rtLoad,
        input logic [4:0] rsUse,
        input logic [4:0] rtUse
    );
        return memRead && (rtLoad != 5'd0) &&
               ((rtLoad == rsUse) || (rtLoad == rtUse));
    endfunction

endpackage

// File: rtl/ex_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath and ex_stall_ctrl.
//   Hazard inputs  : memRead_IDEX, mulStart_IDEX, rt_IDEX, rs_IFID, rt_IFID,
//                    branchTaken_EXMEM
//   Control outputs: pcWrite, ifidWrite, idexWrite, bubble_IDEX, bubble_EXMEM,
//                    flush_IFID, flush_IDEX, exBusy, exDone, stallCount
// modport slave  : the controller (reads hazards, drives controls)
// modport master : the pipeline side (drives hazards, reads controls)
interface ex_stall_ctrl_if;

    logic        memRead_IDEX;
    logic        mulStart_IDEX;
    logic [4:0]  rt_IDEX;
    logic [4:0]  rs_IFID;
    logic [4:0]  rt_IFID;
    logic        branchTaken_EXMEM;

    logic        pcWrite;
    logic        ifidWrite;
    logic        idexWrite;
    logic        bubble_IDEX;
    logic        bubble_EXMEM;
    logic        flush_IFID;
    logic        flush_IDEX;
    logic        exBusy;
    logic        exDone;
    logic [31:0] stallCount;

    modport slave (
        input  memRead_IDEX, mulStart_IDEX, rt_IDEX, rs_IFID, rt_IFID,
               branchTaken_EXMEM,
        output pcWrite, ifidWrite, idexWrite, bubble_IDEX, bubble_EXMEM,
               flush_IFID, flush_IDEX, exBusy, exDone, stallCount
    );

    modport master (
        output memRead_IDEX, mulStart_IDEX, rt_IDEX, rs_IFID, rt_IFID,
               branchTaken_EXMEM,
        input  pcWrite, ifidWrite, idexWrite, bubble_IDEX, bubble_EXMEM,
               flush_IFID, flush_IDEX, exBusy, exDone, stallCount
    );

endinterface

// File: rtl/ex_cycle_counter.sv
// Loadable down-counter tracking the remaining cycles of a multiply.
//   clk, reset : clock and synchronous active-high reset (clears to 0)
//   load       : load loadValue (takes priority over dec)
//   loadValue  : value to load
//   dec        : decrement by one; holds at zero
//   zero       : counter value is zero
module ex_cycle_counter
    import exec_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadValue;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ex_stall_ctrl.sv
// Hazard and execute-stage sequencing controller for the five-stage core.
// Each cycle it decides whether PC, IF/ID and ID/EX advance, stall, take a
// bubble or flush. Covers load-use stalls, taken-branch flushes from EX/MEM
// and multi-cycle multiplies holding EX for MUL_LATENCY cycles.
//   clk, reset : clock, synchronous active-high reset
//   bus        : ex_stall_ctrl_if.slave (hazard inputs, stage controls)
// Parameter MUL_LATENCY (1..16): cycles a multiply occupies EX.
// Optional macro EX_STALL_STATS_EN: builds a saturating stall-cycle counter
// on bus.stallCount; otherwise stallCount reads 0 and no flops are built.
module ex_stall_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 4
) (
    input  logic               clk,
    input  logic               reset,
    ex_stall_ctrl_if.slave     bus
);

    localparam bit MUL_MULTI = (MUL_LATENCY > 1);
    // The accept cycle and the completion cycle are outside the countdown,
    // hence MUL_LATENCY-2 remaining wait cycles after acceptance.
    localparam logic [CNT_W-1:0] MUL_LOAD =
        MUL_MULTI ? CNT_W'(MUL_LATENCY - 2) : '0;

    exState_t state, stateNext;
    logic     cntLoad, cntDec, cntZero;
    logic     loadUse;

    logic pcWrite, ifidWrite, idexWrite;
    logic bubble_IDEX, bubble_EXMEM, flush_IFID, flush_IDEX;
    logic exBusy, exDone;

    assign loadUse = isLoadUse(bus.memRead_IDEX, bus.rt_IDEX,
                               bus.rs_IFID, bus.rt_IFID);

    ex_cycle_counter uCnt (
        .clk       (clk),
        .reset     (reset),
        .load      (cntLoad),
        .loadValue (MUL_LOAD),
        .dec       (cntDec),
        .zero      (cntZero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and counter control
    always_comb begin
        stateNext = state;
        cntLoad   = 1'b0;
        cntDec    = 1'b0;
        case (state)
            RUN: begin
                if (!bus.branchTaken_EXMEM && bus.mulStart_IDEX && MUL_MULTI) begin
                    stateNext = MULWAIT;
                    cntLoad   = 1'b1;
                end
            end
            MULWAIT: begin
                if (cntZero) begin
                    stateNext = RUN;
                end else begin
                    cntDec = 1'b1;
                end
            end
            default: stateNext = RUN;
        endcase
    end

    // Outputs; reset forces defaults so an abandoned multiply never signals done
    always_comb begin
        pcWrite      = 1'b1;
        ifidWrite    = 1'b1;
        idexWrite    = 1'b1;
        bubble_IDEX  = 1'b0;
        bubble_EXMEM = 1'b0;
        flush_IFID   = 1'b0;
        flush_IDEX   = 1'b0;
        exBusy       = 1'b0;
        exDone       = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (bus.branchTaken_EXMEM) begin
                        flush_IFID = 1'b1;
                        flush_IDEX = 1'b1;
                    end else if (bus.mulStart_IDEX && MUL_MULTI) begin
                        pcWrite      = 1'b0;
                        ifidWrite    = 1'b0;
                        idexWrite    = 1'b0;
                        bubble_EXMEM = 1'b1;
                        exBusy       = 1'b1;
                    end else if (bus.mulStart_IDEX) begin
                        exDone = 1'b1;
                    end else if (loadUse) begin
                        pcWrite     = 1'b0;
                        ifidWrite   = 1'b0;
                        bubble_IDEX = 1'b1;
                    end
                end
                MULWAIT: begin
                    if (cntZero) begin
                        exDone = 1'b1;
                    end else begin
                        pcWrite      = 1'b0;
                        ifidWrite    = 1'b0;
                        idexWrite    = 1'b0;
                        bubble_EXMEM = 1'b1;
                        exBusy       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pcWrite      = pcWrite;
    assign bus.ifidWrite    = ifidWrite;
    assign bus.idexWrite    = idexWrite;
    assign bus.bubble_IDEX  = bubble_IDEX;
    assign bus.bubble_EXMEM = bubble_EXMEM;
    assign bus.flush_IFID   = flush_IFID;
    assign bus.flush_IDEX   = flush_IDEX;
    assign bus.exBusy       = exBusy;
    assign bus.exDone       = exDone;

`ifdef EX_STALL_STATS_EN
    logic [31:0] stallCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
        end else if (!pcWrite && (stallCnt != 32'hFFFF_FFFF)) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign bus.stallCount = stallCnt;
`else
    assign bus.stallCount = 32'h0;
`endif

endmodule
